// File: rtl/sensor_cola.sv
// Vehicle-queue model for the side opposite the traffic-light controller.
// Counts arrivals per street, releases one vehicle every DEP_PERIOD green
// cycles, and turns the registered queue counts into the TA/TB sensors.
module sensor_cola #(
  parameter int W          = 4,
  parameter int DEP_PERIOD = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         llegada_A,
  input  logic         llegada_B,
  input  logic [2:0]   LA,
  input  logic [2:0]   LB,
  output logic         TA,
  output logic         TB,
  output logic [W-1:0] cola_A,
  output logic [W-1:0] cola_B,
  output logic         salida_A,
  output logic         salida_B,
  output logic         desborde,
  output logic         error_luz
);

  // Timer only has to reach DEP_PERIOD-1; keep at least one bit so
  // DEP_PERIOD==1 still elaborates (the timer then stays at 0).
  localparam int            TW       = (DEP_PERIOD > 1) ? $clog2(DEP_PERIOD) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(DEP_PERIOD - 1);
  localparam logic [W-1:0]  COLA_MAX = '1;
  localparam logic [2:0]    GREEN    = 3'b001;

  // Index 0 is street A, index 1 is street B.
  logic [W-1:0]  r_cola [2];
  logic [TW-1:0] r_tmr  [2];
  logic [1:0]    r_salida;
  logic          r_desborde;
  logic          r_error_luz;

  logic [2:0]    w_light [2];
  logic [1:0]    w_arr;
  logic          w_illegal;
  logic [1:0]    w_serv;
  logic [1:0]    w_dep;
  logic [1:0]    w_ovf;
  logic [W-1:0]  w_cola_nxt [2];
  logic [TW-1:0] w_tmr_nxt  [2];

  assign w_light[0] = LA;
  assign w_light[1] = LB;
  assign w_arr      = {llegada_B, llegada_A};

  // Both greens at once, or any light that is not one-hot, is a fault.
  assign w_illegal = !$onehot(LA) || !$onehot(LB) || ((LA == GREEN) && (LB == GREEN));

  // Per-street servicing, departure timing and queue arithmetic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_serv = '0;
    w_dep  = '0;
    w_ovf  = '0;
    for (int i = 0; i < 2; i++) begin
      w_cola_nxt[i] = r_cola[i];
      w_tmr_nxt[i]  = '0;

      // The fault inhibits departures in the offending cycle as well.
      w_serv[i] = (w_light[i] == GREEN) && (r_cola[i] != '0) &&
                  !w_illegal && !r_error_luz;
      w_dep[i]  = w_serv[i] && (r_tmr[i] == TMR_LAST);

      // Leaving green (or an empty queue) discards a partial period.
      if (w_serv[i] && !w_dep[i]) begin
        w_tmr_nxt[i] = r_tmr[i] + 1'b1;
      end

      // Arrival and departure together cancel; saturation drops the arrival.
      if (w_arr[i] && !w_dep[i]) begin
        if (r_cola[i] == COLA_MAX) begin
          w_ovf[i] = 1'b1;
        end else begin
          w_cola_nxt[i] = r_cola[i] + 1'b1;
        end
      end else if (w_dep[i] && !w_arr[i]) begin
        w_cola_nxt[i] = r_cola[i] - 1'b1;
      end
    end
  end

  // State registers; reset clears queues, timers and sticky flags at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_cola[i] <= '0;
        r_tmr[i]  <= '0;
      end
      r_salida    <= '0;
      r_desborde  <= 1'b0;
      r_error_luz <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      for (int i = 0; i < 2; i++) begin
        r_cola[i] <= w_cola_nxt[i];
        r_tmr[i]  <= w_tmr_nxt[i];
      end
      r_salida    <= w_dep;
      r_desborde  <= r_desborde | (|w_ovf);
      r_error_luz <= r_error_luz | w_illegal;
    end
  end

  assign cola_A    = r_cola[0];
  assign cola_B    = r_cola[1];
  assign TA        = (r_cola[0] != '0);
  assign TB        = (r_cola[1] != '0);
  assign salida_A  = r_salida[0];
  assign salida_B  = r_salida[1];
  assign desborde  = r_desborde;
  assign error_luz = r_error_luz;

endmodule

// File: tb/tb_sensor_cola.sv
// Self-checking bench for sensor_cola: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural queue model.
module tb_sensor_cola;

  localparam int         W    = 4;
  localparam int         DEP  = 2;
  localparam int         QMAX = (1 << W) - 1;
  localparam logic [2:0] GRN  = 3'b001;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] RED  = 3'b100;

  logic         clk = 1'b0;
  logic         reset;
  logic         llegada_A, llegada_B;
  logic [2:0]   LA, LB;
  logic         TA, TB;
  logic [W-1:0] cola_A, cola_B;
  logic         salida_A, salida_B, desborde, error_luz;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  sensor_cola #(.W(W), .DEP_PERIOD(DEP)) dut (
    .clk       (clk),
    .reset     (reset),
    .llegada_A (llegada_A),
    .llegada_B (llegada_B),
    .LA        (LA),
    .LB        (LB),
    .TA        (TA),
    .TB        (TB),
    .cola_A    (cola_A),
    .cola_B    (cola_B),
    .salida_A  (salida_A),
    .salida_B  (salida_B),
    .desborde  (desborde),
    .error_luz (error_luz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q: vehicles waiting; el: green cycles served toward the next departure.
  typedef struct {
    int qa, qb, ea, eb;
    bit sa, sb, ovf, err;
  } model_t;

  model_t m;

  function automatic bit one_hot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic void street(input int q, input int el, input bit green,
                                 input bit arr, input bit blocked,
                                 output int q_n, output int el_n,
                                 output bit dep, output bit ovf);
    dep  = 1'b0;
    ovf  = 1'b0;
    el_n = 0;
    if (green && q > 0 && !blocked) begin
      if (el + 1 == DEP) dep = 1'b1;
      else               el_n = el + 1;
    end
    q_n = q;
    if (arr && !dep) begin
      if (q == QMAX) ovf = 1'b1;
      else           q_n = q + 1;
    end else if (dep && !arr) begin
      q_n = q - 1;
    end
  endfunction

  function automatic model_t model_next(input model_t c, input bit arr_a, input bit arr_b,
                                        input logic [2:0] la, input logic [2:0] lb);
    model_t n;
    bit     ill, ova, ovb;
    ill = !one_hot(la) || !one_hot(lb) || (la == GRN && lb == GRN);
    street(c.qa, c.ea, la == GRN, arr_a, ill || c.err, n.qa, n.ea, n.sa, ova);
    street(c.qb, c.eb, lb == GRN, arr_b, ill || c.err, n.qb, n.eb, n.sb, ovb);
    n.ovf = c.ovf || ova || ovb;
    n.err = c.err || ill;
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t n;
    n.qa = 0; n.qb = 0; n.ea = 0; n.eb = 0;
    n.sa = 0; n.sb = 0; n.ovf = 0; n.err = 0;
    return n;
  endfunction

  // Model advances with the DUT's edges and resets with it.
  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else       m <= model_next(m, llegada_A, llegada_B, LA, LB);
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cola_A",    cola_A,    m.qa);
      check("cola_B",    cola_B,    m.qb);
      check("TA",        TA,        m.qa != 0);
      check("TB",        TB,        m.qb != 0);
      check("salida_A",  salida_A,  m.sa);
      check("salida_B",  salida_B,  m.sb);
      check("desborde",  desborde,  m.ovf);
      check("error_luz", error_luz, m.err);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive one cycle's inputs, then return just after the edge that used them.
  task automatic tick(input bit a, input bit b, input logic [2:0] la, input logic [2:0] lb);
    @(negedge clk);
    #2;
    llegada_A = a;
    llegada_B = b;
    LA        = la;
    LB        = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    llegada_A = 1'b0;
    llegada_B = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    llegada_A = 1'b0;
    llegada_B = 1'b0;
    LA        = RED;
    LB        = RED;
    #23;
    check("rst_cola_A",    cola_A,    0);
    check("rst_TA",        TA,        0);
    check("rst_error_luz", error_luz, 0);
    check("rst_desborde",  desborde,  0);
    @(negedge clk);
    #2;
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Three arrivals on A while red.
    for (int k = 0; k < 3; k++) tick(1, 0, RED, GRN);
    check("s1_cola_A",   cola_A,   3);
    check("s1_TA",       TA,       1);
    check("s1_salida_A", salida_A, 0);

    // Six green edges drain A: pulses on edges 2, 4, 6.
    for (int k = 1; k <= 6; k++) begin
      tick(0, 0, GRN, RED);
      check($sformatf("s2_salida_A_e%0d", k), salida_A, (k % 2) == 0);
    end
    check("s2_cola_A", cola_A, 0);
    tick(0, 0, GRN, RED);
    check("s2_TA_after", TA, 0);

    // Green, yellow, green: the partial period is discarded.
    tick(1, 0, RED, RED);
    tick(1, 0, RED, RED);
    tick(0, 0, GRN, RED);
    check("s7_no_dep_g1", salida_A, 0);
    tick(0, 0, YEL, RED);
    tick(0, 0, GRN, RED);
    check("s7_no_dep_rg1", salida_A, 0);
    tick(0, 0, GRN, RED);
    check("s7_dep_rg2", salida_A, 1);
    check("s7_cola_A",  cola_A,   1);

    // Fill B to saturation.
    for (int k = 0; k < QMAX; k++) tick(0, 1, RED, RED);
    check("s3_fill_B", cola_B, 15);
    // Arrival together with a departure at saturation: no overflow.
    tick(0, 0, RED, GRN);
    tick(0, 1, RED, GRN);
    check("s4_cola_B",   cola_B,   15);
    check("s4_salida_B", salida_B, 1);
    check("s4_desborde", desborde, 0);
    // Arrival only at saturation: lost, overflow flag set.
    tick(0, 1, RED, RED);
    check("s3_cola_B",   cola_B,   15);
    check("s3_desborde", desborde, 1);

    // Reset between edges with cola_A=5 takes effect immediately.
    for (int k = 0; k < 4; k++) tick(1, 0, RED, RED);
    check("s8_cola_A_pre", cola_A, 5);
    @(negedge clk);
    #2;
    llegada_A = 1'b0;
    reset     = 1'b1;
    #1;
    check("s8_cola_A", cola_A, 0);
    check("s8_TA",     TA,     0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    tick(1, 0, RED, RED);
    check("s9_first_edge", cola_A, 1);

    // Both green: error flag, no departure, arrivals still counted.
    tick(1, 0, RED, RED);
    tick(0, 0, GRN, GRN);
    check("s5_error_luz", error_luz, 1);
    check("s5_salida_A",  salida_A,  0);
    check("s5_cola_A",    cola_A,    2);
    tick(1, 0, GRN, RED);
    check("s5_cola_A_arr", cola_A,  3);
    check("s5_inhibit",    salida_A, 0);

    // Non-one-hot light.
    pulse_reset();
    tick(0, 0, 3'b011, RED);
    check("s6_error_luz", error_luz, 1);

    // Randomized traffic against the model.
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      int         r;
      logic [2:0] la, lb;
      bit         a, b;
      if (c % 400 == 399) pulse_reset();
      r = $urandom_range(0, 199);
      if (r == 0) begin
        la = 3'($urandom);
        lb = 3'($urandom);
      end else begin
        case (r % 6)
          0, 1:    begin la = GRN; lb = RED; end
          2, 3:    begin la = RED; lb = GRN; end
          4:       begin la = YEL; lb = RED; end
          default: begin la = RED; lb = ((c / 50) % 2 == 0) ? YEL : RED; end
        endcase
      end
      // Alternate between light and heavy traffic to reach saturation.
      if ((c / 200) % 2 == 0) begin
        a = ($urandom_range(0, 3) == 0);
        b = ($urandom_range(0, 3) == 0);
      end else begin
        a = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 3) != 0);
      end
      tick(a, b, la, lb);
    end

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sensor_cola.md
SENSOR_COLA -- requirements
Module: sensor_cola

Purpose: vehicle-queue model for the opposite side of the traffic-light controller. It accepts arrival pulses and the decoded lights LA/LB, and produces the sensor inputs TA/TB.

Interface
REQ-001 The module SHALL have these parameters:
- W, default 4: queue counter width.
- DEP_PERIOD, default 2: number of green clock cycles per departing vehicle; legal range 1..15.
REQ-002 The module SHALL have these ports, clock and reset first:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- llegada_A  in  1  Vehicle arrival on street A; sampled each edge; one vehicle per high cycle.
- llegada_B  in  1  Vehicle arrival on street B; same rules as llegada_A.
- LA  in  3  Street A light, one-hot: bit0 green, bit1 yellow, bit2 red.
- LB  in  3  Street B light, same encoding as LA.
- TA  out  1  Street A traffic present; equals (cola_A != 0).
- TB  out  1  Street B traffic present; equals (cola_B != 0).
- cola_A  out  W  Street A queue count, registered.
- cola_B  out  W  Street B queue count, registered.
- salida_A  out  1  Registered one-cycle pulse per vehicle departing street A.
- salida_B  out  1  Registered one-cycle pulse per vehicle departing street B.
- desborde  out  1  Sticky flag: an arrival was lost at a saturated queue.
- error_luz  out  1  Sticky flag: an illegal light combination was sampled.

Function
REQ-003 The block SHALL define illegal(t) as true in any cycle where LA or LB is not exactly one-hot, or where LA==3'b001 and LB==3'b001.
REQ-004 Street X SHALL be "servicing" in a cycle when all of these hold: LX==3'b001, cola_X!=0, illegal(t) false, and error_luz==0.
REQ-005 Each street SHALL have a departure timer tmr_X, sized to hold DEP_PERIOD-1, with this per-edge behaviour:
- If servicing and tmr_X==DEP_PERIOD-1: tmr_X<=0, dep_X=1, salida_X<=1.
- If servicing otherwise: tmr_X<=tmr_X+1, dep_X=0, salida_X<=0.
- If not servicing: tmr_X<=0, dep_X=0, salida_X<=0.
REQ-006 With continuous green and a nonempty queue, the first departure SHALL be registered on the DEP_PERIOD-th edge at which the street is servicing, and each later departure every DEP_PERIOD edges after that.
REQ-007 Yellow, red, or leaving green SHALL clear tmr_X. A partially elapsed period is discarded and restarts from 0 at the next green.
REQ-008 Per street, on each edge, the queue update SHALL be:
- arrival only and cola_X<2^W-1: +1.
- arrival only and cola_X==2^W-1: count unchanged, desborde<=1.
- dep_X only: -1.
- arrival and dep_X together: count unchanged, salida_X still pulses, no overflow.
- neither: count unchanged.
REQ-009 The queue SHALL never wrap: no increment past 2^W-1, and no decrement below 0 (guaranteed by REQ-004).
REQ-010 TA and TB SHALL be combinational decodes of the registered counts, with no extra latency: TA rises in the same cycle cola_A becomes 1.
REQ-011 error_luz SHALL be set on the edge where illegal(t) is true and hold until reset.
REQ-012 Departures SHALL be inhibited starting with the offending cycle itself; arrivals SHALL continue to be counted while error_luz is set.
REQ-013 The two streets SHALL be fully independent except for the shared illegal(t) check and the error_luz inhibit.

Reset
REQ-014 While reset is high, the block SHALL hold these values regardless of clk:
- cola_A=0, cola_B=0, tmr_A=0, tmr_B=0.
- salida_A=0, salida_B=0, desborde=0, error_luz=0; hence TA=0, TB=0.
REQ-015 Assertion of reset in mid-operation SHALL discard queue contents and any partially elapsed timer immediately, without waiting for a clock edge.
REQ-016 After reset is released, the first counting edge SHALL be the first rising clk edge with reset low.

Verification
REQ-017 The bench SHALL cover these directed scenarios (DEP_PERIOD=2, W=4):
- Three arrival cycles on A, LA red -> cola_A=3, TA=1, no salida_A.
- cola_A=3, then LA green and LB red for 6 edges -> salida_A pulses on edges 2, 4, 6; cola_A=0 after edge 6; TA=0 thereafter.
- cola_B=15, arrival on B with LB red -> cola_B stays 15, desborde=1.
- cola_B=15, arrival on B together with a departure -> cola_B stays 15, desborde stays 0.
- LA=LB=3'b001 with cola_A=2 -> error_luz=1 on that edge; no salida_A; cola_A stays 2; a later arrival makes it 3.
- LA=3'b011 -> error_luz=1.
- Green A for 1 edge, then yellow, then green again -> timer restarts; first departure occurs 2 edges after the re-green.
- Reset asserted between clock edges with cola_A=5 -> cola_A=0 and TA=0 immediately.
- Reset released -> the first edge with an arrival gives cola_A=1.
